// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the round-robin FIFO arbiter.
package fifo_arb_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        FLUSH = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic OP_WR = 1'b0;
    localparam logic OP_RD = 1'b1;

    localparam int unsigned DEFAULT_OP_LAT = 2;

    // A write needs room in the FIFO, a read needs something to read.
    function automatic logic is_eligible(input logic req, input logic op,
                                         input logic full, input logic empty);
        return req & ((op == OP_RD) ? ~empty : ~full);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible index after 'last', wrapping.
module rr_pick #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         elig,
    input  logic [$clog2(N)-1:0] last,
    output logic                 valid,
    output logic [$clog2(N)-1:0] idx
);

    localparam int unsigned IW = $clog2(N);

    logic [IW-1:0] cand;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IW'((32'(last) + k) % N);
            if (!valid && elig[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_arbiter.sv
// Shares one FIFO among N clients: one operation at a time, waits the FIFO
// latency, then acknowledges the served client (or the flush requester).
module fifo_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N      = 4,
    parameter int unsigned W      = 8,
    parameter int unsigned OP_LAT = DEFAULT_OP_LAT
) (
    input  logic                 ck,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         op,
    input  logic [N*W-1:0]       wdata,
    output logic [N-1:0]         ack,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic [W-1:0]         rdata,
    input  logic                 flush_req,
    output logic                 flush_ack,
    output logic                 busy,
    output logic                 fifo_insert,
    output logic                 fifo_remove,
    output logic                 fifo_flush,
    output logic [W-1:0]         fifo_din,
    input  logic [W-1:0]         fifo_dout,
    input  logic                 fifo_full,
    input  logic                 fifo_empty
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned CW = (OP_LAT > 1) ? $clog2(OP_LAT) : 1;

    state_t        state;
    logic [IW-1:0] last;
    logic [CW-1:0] cnt;
    logic          cur_op;
    logic          flush_flag;

    logic [N-1:0]  elig;
    logic          pick_valid;
    logic [IW-1:0] pick_idx;

    // FIFO status is only trusted in IDLE, which is the only place elig is used.
    always_comb begin
        elig = '0;
        for (int unsigned i = 0; i < N; i++) begin
            elig[i] = is_eligible(req[i], op[i], fifo_full, fifo_empty);
        end
    end

    rr_pick #(
        .N (N)
    ) u_rr_pick (
        .elig  (elig),
        .last  (last),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Single-process FSM; every output is a register set on entry to its state.
    always_ff @(posedge ck) begin
        if (!reset) begin
            state       <= IDLE;
            last        <= IW'(N - 1);
            cnt         <= '0;
            cur_op      <= OP_WR;
            flush_flag  <= 1'b0;
            gnt_id      <= '0;
            rdata       <= '0;
            fifo_din    <= '0;
            ack         <= '0;
            flush_ack   <= 1'b0;
            busy        <= 1'b0;
            fifo_insert <= 1'b0;
            fifo_remove <= 1'b0;
            fifo_flush  <= 1'b0;
        end else begin
            ack         <= '0;
            flush_ack   <= 1'b0;
            fifo_insert <= 1'b0;
            fifo_remove <= 1'b0;
            fifo_flush  <= 1'b0;

            case (state)
                IDLE: begin
                    if (flush_req) begin
                        state      <= FLUSH;
                        flush_flag <= 1'b1;
                        fifo_flush <= 1'b1;
                        busy       <= 1'b1;
                    end else if (pick_valid) begin
                        state    <= ISSUE;
                        gnt_id   <= pick_idx;
                        last     <= pick_idx;
                        cur_op   <= op[pick_idx];
                        fifo_din <= wdata[32'(pick_idx) * W +: W];
                        busy     <= 1'b1;
                        if (op[pick_idx] == OP_RD) begin
                            fifo_remove <= 1'b1;
                        end else begin
                            fifo_insert <= 1'b1;
                        end
                    end
                end

                ISSUE, FLUSH: begin
                    state <= WAIT;
                    cnt   <= CW'(OP_LAT - 1);
                end

                WAIT: begin
                    if (cnt == '0) begin
                        state <= DONE;
                        if (flush_flag) begin
                            flush_ack <= 1'b1;
                        end else begin
                            ack <= N'(1) << gnt_id;
                            if (cur_op == OP_RD) begin
                                rdata <= fifo_dout;
                            end
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end

                DONE: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    flush_flag <= 1'b0;
                end

                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    flush_flag <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_arbiter.sv
// Self-checking bench: FIFO environment, transaction-level timing reference,
// directed scenarios followed by randomized client traffic.
module tb_fifo_arbiter;
    import fifo_arb_pkg::*;

    localparam int unsigned N      = 4;
    localparam int unsigned W      = 8;
    localparam int unsigned OP_LAT = 2;
    localparam int unsigned IW     = $clog2(N);
    localparam int unsigned DEPTH  = 8;
    localparam int          LAST_T = OP_LAT + 2;

    logic           ck = 1'b0;
    logic           reset;
    logic [N-1:0]   req, op, ack;
    logic [N*W-1:0] wdata;
    logic [IW-1:0]  gnt_id;
    logic [W-1:0]   rdata, fifo_din, fifo_dout;
    logic           flush_req, flush_ack, busy;
    logic           fifo_insert, fifo_remove, fifo_flush, fifo_full, fifo_empty;

    fifo_arbiter #(.N(N), .W(W), .OP_LAT(OP_LAT)) dut (
        .ck(ck), .reset(reset), .req(req), .op(op), .wdata(wdata), .ack(ack),
        .gnt_id(gnt_id), .rdata(rdata), .flush_req(flush_req), .flush_ack(flush_ack),
        .busy(busy), .fifo_insert(fifo_insert), .fifo_remove(fifo_remove),
        .fifo_flush(fifo_flush), .fifo_din(fifo_din), .fifo_dout(fifo_dout),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty)
    );

    always #5 ck = ~ck;

    int vectors = 0, miscompares = 0, cyc = 0;

    // FIFO environment and last-sampled DUT outputs
    logic [W-1:0] fq[$];
    logic [W-1:0] sbq[$];
    logic         s_ins = 0, s_rem = 0, s_fl = 0, s_fack = 0;
    logic [W-1:0] s_din = '0;
    logic [N-1:0] s_ack = '0;

    // Reference: ref_t counts cycles since the service started (0 = idle)
    int           ref_t = 0, ref_kind = 0, ref_last = N - 1;
    bit           ref_pend = 0;
    logic         ref_op = 0;
    logic [W-1:0] ref_wd = '0, ref_rd = '0;

    int           ack_ids[$], ack_cyc[$];
    logic [W-1:0] ack_rd[$];
    int unsigned  rprob = 0, fprob = 0;
    bit           wr_only = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick_drive();
        logic rs;
        @(posedge ck);
        rs = reset;
        #1;
        cyc++;
        if (s_fl) fq.delete();
        else if (s_ins && fq.size() < DEPTH) fq.push_back(s_din);
        else if (s_rem && fq.size() > 0) fifo_dout = fq.pop_front();
        fifo_full  = (fq.size() == DEPTH);
        fifo_empty = (fq.size() == 0);
        for (int i = 0; i < N; i++) begin
            if (s_ack[i]) req[i] = 1'b0;
            else if (!req[i] && rprob != 0 && $urandom_range(99, 0) < rprob) begin
                req[i] = 1'b1;
                op[i]  = wr_only ? 1'b0 : 1'($urandom_range(1, 0));
                wdata[i*W +: W] = W'($urandom);
            end
        end
        if (s_fack) flush_req = 1'b0;
        else if (!flush_req && fprob != 0 && $urandom_range(99, 0) < fprob) flush_req = 1'b1;
        if (!rs) begin
            ref_t = 0; ref_pend = 0; ref_last = N - 1;
        end else if (ref_pend) begin
            ref_pend = 0; ref_t = 1;
            if (ref_kind < 0) sbq.delete();
            else if (ref_op == 1'b0) sbq.push_back(ref_wd);
            else ref_rd = (sbq.size() > 0) ? sbq.pop_front() : '0;
        end else if (ref_t > 0) begin
            ref_t++;
            if (ref_t > LAST_T) ref_t = 0;
        end
    endtask

    task automatic tick_check();
        logic [N-1:0] eack;
        bit cl, wr, rd;
        @(negedge ck);
        s_ins = fifo_insert; s_rem = fifo_remove; s_fl = fifo_flush;
        s_din = fifo_din; s_ack = ack; s_fack = flush_ack;
        cl = (ref_kind >= 0);
        wr = cl && (ref_op == 1'b0);
        rd = cl && (ref_op == 1'b1);
        eack = (ref_t == LAST_T && cl) ? N'(1) << ref_kind : '0;
        chk("busy",      32'(busy),        32'(ref_t > 0));
        chk("insert",    32'(fifo_insert), 32'(ref_t == 1 && wr));
        chk("remove",    32'(fifo_remove), 32'(ref_t == 1 && rd));
        chk("flush",     32'(fifo_flush),  32'(ref_t == 1 && !cl));
        chk("ack",       32'(ack),         32'(eack));
        chk("flush_ack", 32'(flush_ack),   32'(ref_t == LAST_T && !cl));
        if (cl && ref_t >= 1) chk("gnt_id", 32'(gnt_id), 32'(ref_kind));
        if (wr && ref_t >= 1 && ref_t <= OP_LAT + 1) chk("fifo_din", 32'(fifo_din), 32'(ref_wd));
        if (rd && ref_t == LAST_T) chk("rdata", 32'(rdata), 32'(ref_rd));
        for (int i = 0; i < N; i++) begin
            if (ack[i]) begin
                ack_ids.push_back(i); ack_rd.push_back(rdata); ack_cyc.push_back(cyc);
            end
        end
        // Service decision made from the inputs the DUT samples at the next edge
        if (ref_t == 0 && !ref_pend && reset) begin
            if (flush_req) begin
                ref_kind = -1; ref_pend = 1;
            end else begin
                for (int k = 1; k <= N; k++) begin
                    int i;
                    i = (ref_last + k) % N;
                    if (req[i] && (op[i] ? !fifo_empty : !fifo_full)) begin
                        ref_kind = i; ref_op = op[i]; ref_wd = wdata[i*W +: W];
                        ref_last = i; ref_pend = 1;
                        break;
                    end
                end
            end
        end
    endtask

    task automatic step();
        tick_drive();
        tick_check();
    endtask

    task automatic collect(input string tag, input int want, input int budget);
        int n = 0;
        while (ack_ids.size() < want && n < budget) begin
            step();
            n++;
        end
        chk(tag, 32'(ack_ids.size()), 32'(want));
    endtask

    // Run until idle; withdraw requests the FIFO state can never serve right now.
    task automatic drain();
        int n = 0;
        while ((req != '0 || flush_req || ref_t != 0 || ref_pend) && n < 300) begin
            tick_drive();
            for (int i = 0; i < N; i++) begin
                if (req[i] && !((ref_t > 0 || ref_pend) && ref_kind == i) &&
                    (op[i] ? fifo_empty : fifo_full))
                    req[i] = 1'b0;
            end
            tick_check();
            n++;
        end
        chk("drain_done", 32'(n < 300), 32'd1);
    endtask

    task automatic set_client(input int i, input logic o, input logic [W-1:0] d);
        req[i] = 1'b1; op[i] = o; wdata[i*W +: W] = d;
    endtask

    initial begin
        int n;
        reset = 1'b0; req = '0; op = '0; wdata = '0; flush_req = 1'b0;
        fifo_full = 1'b0; fifo_empty = 1'b1; fifo_dout = '0;
        step(); step();
        chk("rst_gnt_id", 32'(gnt_id), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        tick_drive(); reset = 1'b1; tick_check();

        // Single write from client 1, exact cycle timing
        tick_drive(); set_client(1, OP_WR, 8'hA5); tick_check();
        for (int c = 1; c <= 5; c++) begin
            step();
            if (c == 1) begin
                chk("t2_insert", 32'(fifo_insert), 32'd1);
                chk("t2_din", 32'(fifo_din), 32'hA5);
            end
            chk("t2_busy", 32'(busy), 32'(c <= 4));
            if (c == 4) chk("t2_ack", 32'(ack), 32'b0010);
        end

        // Reset held two cycles in the middle of a write's WAIT
        tick_drive(); set_client(3, OP_WR, 8'h11); tick_check();
        step(); step();
        tick_drive(); reset = 1'b0; req[3] = 1'b0; tick_check();
        tick_drive(); tick_check();
        chk("t1_ack_aborted", 32'(ack), 32'd0);
        tick_drive(); reset = 1'b1; tick_check();
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_gnt_id", 32'(gnt_id), 32'd0);
        chk("t1_fifo_din", 32'(fifo_din), 32'd0);
        chk("t1_strobes", 32'({fifo_insert, fifo_remove, fifo_flush}), 32'd0);
        ack_ids.delete(); ack_rd.delete(); ack_cyc.delete();
        tick_drive(); set_client(0, OP_WR, 8'h21); set_client(2, OP_WR, 8'h22); tick_check();
        collect("t1_ack_count", 2, 40);
        if (ack_ids.size() >= 2) begin
            chk("t1_first", 32'(ack_ids[0]), 32'd0);
            chk("t1_second", 32'(ack_ids[1]), 32'd2);
        end
        drain();

        // Flush beats a simultaneous client request
        tick_drive(); flush_req = 1'b1; set_client(2, OP_WR, 8'h5A); tick_check();
        for (int c = 1; c <= 7; c++) begin
            step();
            if (c == 1) chk("t5_flush", 32'(fifo_flush), 32'd1);
            if (c == 4) chk("t5_flush_ack", 32'(flush_ack), 32'd1);
            if (c == 6) begin
                chk("t5_insert", 32'(fifo_insert), 32'd1);
                chk("t5_gnt", 32'(gnt_id), 32'd2);
            end
        end
        drain();
        tick_drive(); flush_req = 1'b1; tick_check();
        drain();

        // Read on empty FIFO waits for a write, then returns that data
        ack_ids.delete(); ack_rd.delete(); ack_cyc.delete();
        tick_drive(); set_client(3, OP_RD, 8'h00); set_client(0, OP_WR, 8'h3C); tick_check();
        collect("t4_ack_count", 2, 40);
        if (ack_ids.size() >= 2) begin
            chk("t4_first", 32'(ack_ids[0]), 32'd0);
            chk("t4_second", 32'(ack_ids[1]), 32'd3);
            chk("t4_rdata", 32'(ack_rd[1]), 32'h3C);
        end
        drain();

        // All clients writing continuously: strict rotation, fixed period
        ack_ids.delete(); ack_rd.delete(); ack_cyc.delete();
        tick_drive();
        for (int i = 0; i < N; i++) set_client(i, OP_WR, W'($urandom));
        rprob = 100; wr_only = 1;
        tick_check();
        collect("t3_ack_count", 5, 60);
        rprob = 0; wr_only = 0;
        if (ack_ids.size() >= 5) begin
            for (int k = 0; k < 5; k++) chk("t3_order", 32'(ack_ids[k]), 32'(k % N));
            for (int k = 1; k < 5; k++) chk("t3_period", 32'(ack_cyc[k] - ack_cyc[k-1]), 32'(OP_LAT + 3));
        end
        drain();

        // Full FIFO: the reader is served, the blocked writer follows
        n = 0;
        while (!fifo_full && n < 200) begin
            tick_drive();
            if (!req[1] && !s_ack[1]) set_client(1, OP_WR, W'($urandom));
            tick_check();
            n++;
        end
        chk("t6_fill_done", 32'(n < 200), 32'd1);
        drain();
        ack_ids.delete(); ack_rd.delete(); ack_cyc.delete();
        tick_drive(); set_client(0, OP_WR, 8'h77); set_client(1, OP_RD, 8'h00); tick_check();
        collect("t6_ack_count", 2, 40);
        if (ack_ids.size() >= 2) begin
            chk("t6_first", 32'(ack_ids[0]), 32'd1);
            chk("t6_second", 32'(ack_ids[1]), 32'd0);
        end
        drain();

        // Randomized traffic with occasional flushes
        rprob = 25; fprob = 2;
        repeat (2000) step();
        rprob = 0; fprob = 0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
